pipe_hazard_ctrl: RTL

Central hazard controller for the 5-stage pipelined CPU. It evaluates ID-stage source operands against in-flight EX/MEM destinations and produces forwarding selects. It also produces the stall enables that freeze the PC and IF/ID pipeline registers, the bubble that clears ID/EX, and the flush that clears IF/ID on a taken branch. An internal FSM interlocks the multi-cycle multiply/divide unit.

---
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and the hazard controller.
//   ID inputs  : id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_use,
//                id_branch_taken
//   EX inputs  : ex_rn, ex_wreg, ex_m2reg
//   MEM inputs : mem_rn, mem_wreg, mem_m2reg
//   Controls   : stall_pc, stall_ifid, bubble_idex, flush_ifid, fwda, fwdb
//   Mul/div    : md_busy, md_done
//   Stats      : stall_cnt (CNT_W bits, saturating)
// master = datapath side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_md_start;
   logic             id_md_use;
   logic             id_branch_taken;
   logic [4:0]       ex_rn;
   logic             ex_wreg;
   logic             ex_m2reg;
   logic [4:0]       mem_rn;
   logic             mem_wreg;
   logic             mem_m2reg;
   logic             stall_pc;
   logic             stall_ifid;
   logic             bubble_idex;
   logic             flush_ifid;
   logic [1:0]       fwda;
   logic [1:0]       fwdb;
   logic             md_busy;
   logic             md_done;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_use, id_branch_taken,
      output ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg,
      input  stall_pc, stall_ifid, bubble_idex, flush_ifid, fwda, fwdb,
      input  md_busy, md_done, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_use, id_branch_taken,
      input  ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg,
      output stall_pc, stall_ifid, bubble_idex, flush_ifid, fwda, fwdb,
      output md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for the 5-stage pipeline: operand forwarding selects,
// load-use and mul/div interlock stalls, branch flush of IF/ID, a small FSM
// tracking the multi-cycle mul/div unit, and a saturating stall-cycle counter.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   hz   : slave side of pipe_hazard_ctrl_if (see interface header)
// CNT_W must match the CNT_W of the connected interface.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned MD_LAT = 4,   // 2..15
   parameter int unsigned CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam logic [3:0] MdLoad = 4'(MD_LAT - 1);

   typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

   md_state_e        state_q, state_d;
   logic [3:0]       md_cnt_q, md_cnt_d;
   logic             md_done_q, md_done_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       lu, mdh, stall, busy;
   logic [1:0] fwda, fwdb;

   // EX load data is not available yet, so an EX load never forwards; that
   // case is covered by the load-use stall instead.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rn,
      input logic [4:0] ex_rn,
      input logic       ex_wreg,
      input logic       ex_m2reg,
      input logic [4:0] mem_rn,
      input logic       mem_wreg,
      input logic       mem_m2reg
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (rn != 5'd0) begin
         if (ex_wreg && !ex_m2reg && (ex_rn == rn)) begin
            sel = 2'b01;
         end else if (mem_wreg && (mem_rn == rn)) begin
            sel = {1'b1, mem_m2reg};
         end
      end
      return sel;
   endfunction

   always_comb begin
      lu    = 1'b0;
      mdh   = 1'b0;
      stall = 1'b0;
      busy  = 1'b0;
      fwda  = 2'b00;
      fwdb  = 2'b00;
      if (!rst) begin
         busy = (state_q == StBusy);
         lu   = hz.ex_wreg && hz.ex_m2reg && (hz.ex_rn != 5'd0) &&
                ((hz.id_use_rs && (hz.ex_rn == hz.id_rs)) ||
                 (hz.id_use_rt && (hz.ex_rn == hz.id_rt)));
         mdh  = busy && (hz.id_md_start || hz.id_md_use);
         stall = lu || mdh;
         fwda = fwd_sel(hz.id_rs, hz.ex_rn, hz.ex_wreg, hz.ex_m2reg,
                        hz.mem_rn, hz.mem_wreg, hz.mem_m2reg);
         fwdb = fwd_sel(hz.id_rt, hz.ex_rn, hz.ex_wreg, hz.ex_m2reg,
                        hz.mem_rn, hz.mem_wreg, hz.mem_m2reg);
      end
   end

   // Mul/div FSM next state. A start held off by the busy interlock is picked
   // up in the first IDLE cycle, since mdh is then zero.
   always_comb begin
      state_d   = state_q;
      md_cnt_d  = md_cnt_q;
      md_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hz.id_md_start && !lu) begin
               state_d  = StBusy;
               md_cnt_d = MdLoad;
            end
         end
         StBusy: begin
            if (md_cnt_q == 4'd0) begin
               state_d   = StIdle;
               md_done_d = 1'b1;
            end else begin
               md_cnt_d = md_cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         md_cnt_q    <= 4'd0;
         md_done_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         md_done_q   <= md_done_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall_pc    = stall;
   assign hz.stall_ifid  = stall;
   assign hz.bubble_idex = stall;
   // A stalled branch keeps its slot; the flush happens once the stall lifts.
   assign hz.flush_ifid  = !rst && hz.id_branch_taken && !stall;
   assign hz.fwda        = fwda;
   assign hz.fwdb        = fwdb;
   assign hz.md_busy     = busy;
   assign hz.md_done     = md_done_q;
   assign hz.stall_cnt   = stall_cnt_q;

endmodule
